// File: rtl/retire_checker.sv
// retire_checker
//   Self-check monitor that sits on the retirement stream. Each retired
//   microinstruction is matched against a programmable label table. The
//   result is a PASS/FAIL/TIMEOUT verdict plus a FIFO of checkpoint hits.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   start             IDLE -> RUN pulse
//   retire, pc_x,     retirement stream (opcode fields: sqi=[112:109],
//   opcode_x            a=[108:97], map=[96:95])
//   cfg_we, cfg_idx,  label table write port (IDLE only)
//   cfg_kind, cfg_addr  kind: 0=OFF 1=FAIL 2=CKPT 3=FINISH
//   wdog_limit        watchdog cycle limit (0 disables)
//   status, done      0=IDLE 1=RUN 2=PASS 3=FAIL 4=TIMEOUT
//   fail_idx          table index of the FAIL entry that hit
//   ckpt_count        saturating checkpoint hit count
//   evt_valid/ready,  checkpoint event FIFO head
//   evt_idx, evt_pc
//   evt_ovf           sticky: an event was dropped on a full FIFO
//
// Build option
//   RETCHK_WATCHDOG_EN  enables the RUN-cycle watchdog and the TIMEOUT state.
//
// State   | meaning
// --------+-----------------------------------------------
// IDLE    | table writable, retires ignored, waits for start
// RUN     | retires matched against the table
// PASS    | FINISH entry hit (terminal until reset)
// FAIL    | FAIL entry hit (terminal until reset)
// TIMEOUT | watchdog expired (terminal until reset)

module retire_checker #(
    parameter int NLABELS    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int WDOG_W     = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              retire,
    input  logic [11:0]       pc_x,
    input  logic [112:1]      opcode_x,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_idx,
    input  logic [1:0]        cfg_kind,
    input  logic [11:0]       cfg_addr,
    input  logic [WDOG_W-1:0] wdog_limit,
    output logic [2:0]        status,
    output logic              done,
    output logic [3:0]        fail_idx,
    output logic [15:0]       ckpt_count,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [3:0]        evt_idx,
    output logic [11:0]       evt_pc,
    output logic              evt_ovf
);

    localparam logic [1:0] K_FAIL = 2'd1;
    localparam logic [1:0] K_CKPT = 2'd2;
    localparam logic [1:0] K_FIN  = 2'd3;
    localparam int         PW     = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_kind [NLABELS];
    logic [11:0] r_addr [NLABELS];

    // Retire is registered once so the wide table compare starts from flops.
    logic        r_ret_v;
    logic [11:0] r_ret_pc;
    logic [11:0] r_ret_a;
    logic        r_ret_cont_pe;

    logic        w_fail_hit, w_fin_hit, w_ckpt_hit;
    logic [3:0]  w_fail_idx, w_ckpt_idx;
    logic        w_act, w_push, w_pop, w_push_ok;
    logic        w_wdog_hit;
    logic        w_unused;

    logic [3:0]  r_fifo_idx [FIFO_DEPTH];
    logic [11:0] r_fifo_pc  [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_count;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_fail_hit = 1'b0;
        w_fin_hit  = 1'b0;
        w_ckpt_hit = 1'b0;
        w_fail_idx = '0;
        w_ckpt_idx = '0;
        for (int i = NLABELS - 1; i >= 0; i--) begin
            if (r_kind[i] == K_FAIL && r_addr[i] == r_ret_pc) begin
                w_fail_hit = 1'b1;
                w_fail_idx = 4'(i);
            end
            if (r_kind[i] == K_FIN && r_addr[i] == r_ret_pc) begin
                w_fin_hit = 1'b1;
            end
            if (r_kind[i] == K_CKPT && r_ret_cont_pe && r_addr[i] == r_ret_a) begin
                w_ckpt_hit = 1'b1;
                w_ckpt_idx = 4'(i);
            end
        end
    end

    assign w_act     = r_ret_v && (r_state == S_RUN);
    assign w_push    = w_act && !w_fail_hit && !w_fin_hit && w_ckpt_hit;
    assign w_pop     = (r_count != '0) && evt_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO survives.
    assign w_push_ok = w_push && ((r_count != (PW+1)'(FIFO_DEPTH)) || w_pop);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_act && w_fail_hit)     w_state_nxt = S_FAIL;
                else if (w_act && w_fin_hit) w_state_nxt = S_PASS;
                else if (w_wdog_hit)         w_state_nxt = S_TIMEOUT;
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_ret_v       <= 1'b0;
            r_ret_pc      <= '0;
            r_ret_a       <= '0;
            r_ret_cont_pe <= 1'b0;
            fail_idx      <= '0;
            ckpt_count    <= '0;
            evt_ovf       <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            for (int i = 0; i < NLABELS; i++) begin
                r_kind[i] <= '0;
                r_addr[i] <= '0;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_ret_v       <= retire && (r_state == S_RUN);
            r_ret_pc      <= pc_x;
            r_ret_a       <= opcode_x[108:97];
            r_ret_cont_pe <= (opcode_x[112:109] == 4'd14) && (opcode_x[96:95] == 2'd0);

            if (r_state == S_IDLE && cfg_we) begin
                for (int i = 0; i < NLABELS; i++) begin
                    if (cfg_idx == 4'(i)) begin
                        r_kind[i] <= cfg_kind;
                        r_addr[i] <= cfg_addr;
                    end
                end
            end

            if (w_act && w_fail_hit) fail_idx <= w_fail_idx;

            if (w_push && ckpt_count != 16'hFFFF) ckpt_count <= ckpt_count + 16'd1;
            if (w_push && !w_push_ok) evt_ovf <= 1'b1;

            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo_idx[r_wr_ptr] <= w_ckpt_idx;
            r_fifo_pc[r_wr_ptr]  <= r_ret_pc;
        end
    end

`ifdef RETCHK_WATCHDOG_EN
    logic [WDOG_W-1:0] r_wdog;

    always_ff @(posedge clk) begin
        if (!reset)                         r_wdog <= '0;
        else if (r_state == S_IDLE && start) r_wdog <= '0;
        else if (r_state == S_RUN)          r_wdog <= r_wdog + 1'b1;
    end

    assign w_wdog_hit = (r_state == S_RUN) && (wdog_limit != '0) && (r_wdog == wdog_limit);
    assign w_unused   = ^opcode_x[94:1];
`else
    assign w_wdog_hit = 1'b0;
    assign w_unused   = ^{opcode_x[94:1], wdog_limit};
`endif

    assign status    = r_state;
    assign done      = (r_state == S_PASS) || (r_state == S_FAIL) || (r_state == S_TIMEOUT);
    assign evt_valid = (r_count != '0);
    assign evt_idx   = evt_valid ? r_fifo_idx[r_rd_ptr] : '0;
    assign evt_pc    = evt_valid ? r_fifo_pc[r_rd_ptr] : '0;

endmodule

// File: tb/tb_retire_checker.sv
module tb_retire_checker;

    localparam int NL = 8;
    localparam int FD = 4;
    localparam int WW = 24;

    logic          clk = 1'b0;
    logic          reset, start, retire, cfg_we, evt_ready;
    logic [11:0]   pc_x, cfg_addr;
    logic [112:1]  opcode_x;
    logic [3:0]    cfg_idx;
    logic [1:0]    cfg_kind;
    logic [WW-1:0] wdog_limit;
    logic [2:0]    status;
    logic          done, evt_valid, evt_ovf;
    logic [3:0]    fail_idx, evt_idx;
    logic [15:0]   ckpt_count;
    logic [11:0]   evt_pc;

    always #5 clk = ~clk;

    retire_checker #(.NLABELS(NL), .FIFO_DEPTH(FD), .WDOG_W(WW)) dut (
        .clk(clk), .reset(reset), .start(start), .retire(retire),
        .pc_x(pc_x), .opcode_x(opcode_x),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_kind(cfg_kind), .cfg_addr(cfg_addr),
        .wdog_limit(wdog_limit),
        .status(status), .done(done), .fail_idx(fail_idx), .ckpt_count(ckpt_count),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
        .evt_pc(evt_pc), .evt_ovf(evt_ovf)
    );

    typedef struct { int idx; int pc; } ev_t;

    int   n_checks = 0;
    int   n_err    = 0;
    ev_t  exp_q[$];
    int   got_pc[$];

    // Reference model: verdict, counters, table and one-deep retire latency.
    bit            m_live = 0;
    int            m_state, m_fidx, m_ck, m_wd;
    bit            m_ovf;
    int            m_kind [NL];
    int            m_addr [NL];
    bit            p_v;
    int            p_pc;
    logic [112:1]  p_op;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // kind: 0 none, 1 FAIL, 2 CKPT, 3 FINISH; idx of the winning entry.
    function automatic void judge(input int pc, input logic [112:1] op,
                                  output int kind, output int idx);
        kind = 0;
        idx  = 0;
        for (int i = 0; i < NL; i++)
            if (m_kind[i] == 1 && m_addr[i] == pc) begin kind = 1; idx = i; return; end
        for (int i = 0; i < NL; i++)
            if (m_kind[i] == 3 && m_addr[i] == pc) begin kind = 3; idx = i; return; end
        if (op[112:109] == 4'd14 && op[96:95] == 2'd0)
            for (int i = 0; i < NL; i++)
                if (m_kind[i] == 2 && m_addr[i] == int'(op[108:97])) begin kind = 2; idx = i; return; end
    endfunction

    task automatic model_step();
        int st0, k, ix;
        if (!reset) begin
            m_state = 0; m_fidx = 0; m_ck = 0; m_ovf = 0; m_wd = 0; p_v = 0;
            for (int i = 0; i < NL; i++) begin m_kind[i] = 0; m_addr[i] = 0; end
            exp_q.delete();
            m_live = 1;
            return;
        end
        st0 = m_state;
        if (st0 == 1) begin
            k = 0; ix = 0;
            if (p_v) judge(p_pc, p_op, k, ix);
            if (k == 1) begin
                m_state = 3; m_fidx = ix;
            end else if (k == 3) begin
                m_state = 2;
            end else begin
                if (k == 2) begin
                    if (m_ck < 65535) m_ck++;
                    if (exp_q.size() < FD) exp_q.push_back('{ix, p_pc});
                    else m_ovf = 1;
                end
`ifdef RETCHK_WATCHDOG_EN
                if (wdog_limit != 0 && m_wd == int'(wdog_limit)) m_state = 4;
`endif
            end
            m_wd++;
        end
        p_v  = (st0 == 1) && retire;
        p_pc = int'(pc_x);
        p_op = opcode_x;
        if (st0 == 0) begin
            if (cfg_we && int'(cfg_idx) < NL) begin
                m_kind[cfg_idx] = int'(cfg_kind);
                m_addr[cfg_idx] = int'(cfg_addr);
            end
            if (start) begin m_state = 1; m_wd = 0; end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: state compared every cycle, events popped as the DUT hands them over.
    ev_t e;
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("status", 64'(status), 64'(m_state));
            chk("done", 64'(done), 64'(m_state >= 2));
            chk("fail_idx", 64'(fail_idx), 64'(m_fidx));
            chk("ckpt_count", 64'(ckpt_count), 64'(m_ck));
            chk("evt_ovf", 64'(evt_ovf), 64'(m_ovf));
            chk("evt_valid", 64'(evt_valid), 64'(exp_q.size() != 0));
            if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL evt_unexpected: got idx %0d pc %0d expected no event", evt_idx, evt_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_idx", 64'(evt_idx), 64'(e.idx));
                    chk("evt_pc", 64'(evt_pc), 64'(e.pc));
                    got_pc.push_back(int'(evt_pc));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [112:1] mkop(input int sqi, input int a, input int map);
        logic [112:1] o;
        o[32:1]    = $urandom;
        o[64:33]   = $urandom;
        o[96:65]   = $urandom;
        o[112:97]  = 16'($urandom);
        o[112:109] = 4'(sqi);
        o[108:97]  = 12'(a);
        o[96:95]   = 2'(map);
        return o;
    endfunction

    task automatic do_reset();
        reset = 1'b0; tick(1); reset = 1'b1;
    endtask

    task automatic cfg(input int idx, input int kind, input int addr);
        cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_kind = 2'(kind); cfg_addr = 12'(addr);
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic retire1(input int pc, input logic [112:1] op);
        retire = 1'b1; pc_x = 12'(pc); opcode_x = op;
        tick(1);
        retire = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; retire = 1'b0; cfg_we = 1'b0; evt_ready = 1'b1;
        pc_x = '0; opcode_x = '0; cfg_idx = '0; cfg_kind = '0; cfg_addr = '0; wdog_limit = '0;
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_evt_idx", 64'(evt_idx), 64'd0);
        chk("rst_evt_pc", 64'(evt_pc), 64'd0);

        // T1: FINISH hit
        cfg(0, 1, 1277); cfg(1, 3, 1272);
        start_run();
        retire1(1272, mkop(0, 0, 0));
        tick(1);
        chk("t1_status", 64'(status), 64'd2);
        chk("t1_done", 64'(done), 64'd1);

        // T2: checkpoint hit, then map!=PE miss
        do_reset();
        cfg(2, 2, 13);
        start_run();
        evt_ready = 1'b0;
        retire1(555, mkop(14, 13, 0));
        tick(1);
        chk("t2_ckpt", 64'(ckpt_count), 64'd1);
        chk("t2_valid", 64'(evt_valid), 64'd1);
        chk("t2_idx", 64'(evt_idx), 64'd2);
        chk("t2_pc", 64'(evt_pc), 64'd555);
        evt_ready = 1'b1;
        tick(1);
        retire1(556, mkop(14, 13, 1));
        tick(2);
        chk("t2_ckpt_nohit", 64'(ckpt_count), 64'd1);

        // T3: FAIL beats FINISH on the same address
        do_reset();
        cfg(0, 1, 1277); cfg(1, 3, 1277);
        start_run();
        retire1(1277, mkop(0, 0, 0));
        tick(1);
        chk("t3_status", 64'(status), 64'd3);
        chk("t3_fail_idx", 64'(fail_idx), 64'd0);

        // T4: overflow with consumer stalled
        do_reset();
        cfg(3, 2, 40);
        start_run();
        evt_ready = 1'b0;
        got_pc.delete();
        for (int k = 0; k < 5; k++) begin
            retire = 1'b1; pc_x = 12'(100 + k); opcode_x = mkop(14, 40, 0);
            tick(1);
        end
        retire = 1'b0;
        tick(2);
        chk("t4_ckpt", 64'(ckpt_count), 64'd5);
        chk("t4_ovf", 64'(evt_ovf), 64'd1);
        evt_ready = 1'b1;
        tick(6);
        chk("t4_drained", 64'(got_pc.size()), 64'd4);
        for (int k = 0; k < got_pc.size(); k++)
            chk("t4_order", 64'(got_pc[k]), 64'(100 + k));

        // T5: reset mid-RUN with a non-empty FIFO
        evt_ready = 1'b0;
        do_reset();
        cfg(0, 2, 7);
        start_run();
        retire1(300, mkop(14, 7, 0));
        tick(1);
        chk("t5_pre_valid", 64'(evt_valid), 64'd1);
        do_reset();
        chk("t5_status", 64'(status), 64'd0);
        chk("t5_valid", 64'(evt_valid), 64'd0);
        retire1(1272, mkop(0, 0, 0));
        tick(2);
        chk("t5_idle", 64'(status), 64'd0);
        evt_ready = 1'b1;

`ifdef RETCHK_WATCHDOG_EN
        // T6: watchdog
        do_reset();
        wdog_limit = 24'd100;
        start_run();
        n = 0;
        while (status != 3'd4 && n < 120) begin tick(1); n++; end
        chk("t6_timeout_cycle", 64'(n), 64'd101);
        cfg(0, 3, 5);
        chk("t6_stays", 64'(status), 64'd4);
        wdog_limit = '0;
`endif

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < NL + 2; i++) begin
                int kd;
                kd = $urandom_range(0, 3);
                cfg(i, kd, (kd == 2) ? $urandom_range(0, 7) : $urandom_range(0, 255));
            end
            start_run();
            n = 0;
            while (!done && n < 400) begin
                retire    = ($urandom_range(0, 1) == 1);
                pc_x      = 12'($urandom_range(0, 255));
                opcode_x  = mkop(($urandom_range(0, 1) == 1) ? 14 : $urandom_range(0, 15),
                                 $urandom_range(0, 7),
                                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
                evt_ready = ($urandom_range(0, 3) != 0);
                cfg_we    = ($urandom_range(0, 15) == 0);
                cfg_idx   = 4'($urandom_range(0, 15));
                cfg_kind  = 2'($urandom_range(0, 3));
                cfg_addr  = 12'($urandom_range(0, 255));
                start     = ($urandom_range(0, 15) == 0);
                tick(1);
                n++;
            end
            retire = 1'b0; cfg_we = 1'b0; start = 1'b0; evt_ready = 1'b1;
            tick(4 + FD);
            chk("rand_drain", 64'(exp_q.size()), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
